// File: rtl/conv_tap_feeder_if.sv
// Bundle for conv_tap_feeder: config port, input sample stream and per-tap output bus.
interface conv_tap_feeder_if;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ack;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [31:0] in_data;
  logic [31:0] weight;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_first;
  logic        out_last;
  logic [3:0]  out_tap;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, s_valid, s_data, s_last,
    input  cfg_ack, s_ready, in_data, weight, bias, out_valid, out_first, out_last, out_tap
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, s_valid, s_data, s_last,
    output cfg_ack, s_ready, in_data, weight, bias, out_valid, out_first, out_last, out_tap
  );
endinterface

// File: rtl/conv_tap_feeder.sv
// Collects a sliding 1-D window of FP32 samples and replays it one tap per cycle,
// paired with its weight, to a downstream multiply-accumulate unit.
module conv_tap_feeder #(
  parameter int unsigned KERNEL_TAPS = 9
) (
  input  logic               clk,
  input  logic               reset,
  conv_tap_feeder_if.slave   bus
);
  localparam int unsigned DW   = 32;
  localparam int unsigned TW   = 4;
  localparam int unsigned CW   = 5;
  localparam int unsigned MAXT = 16;
  localparam logic [4:0]    BIAS_ADDR = 5'h1F;
  localparam logic [TW-1:0] LAST_TAP  = TW'(KERNEL_TAPS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(KERNEL_TAPS);

  typedef enum logic {FILL, ISSUE} state_t;

  state_t          state;
  logic [DW-1:0]   win_q [MAXT];
  logic [DW-1:0]   wt_q  [MAXT];
  logic [CW-1:0]   fill_cnt;
  logic            clear_pend;

  logic            accept;
  logic            cfg_ok;
  logic            completes;
  logic [DW-1:0]   w0_new;
  logic [DW-1:0]   tap0_data;
  logic [TW-1:0]   nxt_tap;

  // Tap 0 is registered on the accept edge, so it sees the post-shift window and a same-cycle weight write.
  always_comb begin
    accept    = bus.s_valid && bus.s_ready;
    cfg_ok    = bus.cfg_we && (state == FILL) &&
                ((bus.cfg_addr < CW'(KERNEL_TAPS)) || (bus.cfg_addr == BIAS_ADDR));
    completes = fill_cnt >= CW'(KERNEL_TAPS - 1);
    w0_new    = (cfg_ok && (bus.cfg_addr == 5'd0)) ? bus.cfg_wdata : wt_q[0];
    tap0_data = (KERNEL_TAPS == 1) ? bus.s_data : win_q[1];
    nxt_tap   = TW'(bus.out_tap + TW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      fill_cnt   <= '0;
      clear_pend <= 1'b0;
      for (int unsigned i = 0; i < MAXT; i++) begin
        win_q[TW'(i)] <= '0;
        wt_q[TW'(i)]  <= '0;
      end
      bus.bias      <= '0;
      bus.cfg_ack   <= 1'b0;
      bus.s_ready   <= 1'b0;
      bus.in_data   <= '0;
      bus.weight    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_tap   <= '0;
    end else begin
      bus.cfg_ack <= cfg_ok;
      if (cfg_ok) begin
        if (bus.cfg_addr == BIAS_ADDR) bus.bias <= bus.cfg_wdata;
        else                           wt_q[bus.cfg_addr[TW-1:0]] <= bus.cfg_wdata;
      end

      case (state)
        FILL: begin
          bus.s_ready <= 1'b1;
          if (accept) begin
            if (bus.s_last && !completes) begin
              // Frame ended short of a full window: discard partial history.
              fill_cnt <= '0;
              for (int unsigned i = 0; i < MAXT; i++) win_q[TW'(i)] <= '0;
            end else begin
              for (int unsigned i = 0; i + 1 < KERNEL_TAPS; i++) win_q[TW'(i)] <= win_q[TW'(i + 1)];
              win_q[TW'(KERNEL_TAPS - 1)] <= bus.s_data;
              fill_cnt <= completes ? FULL_CNT : CW'(fill_cnt + CW'(1));
              if (completes) begin
                state         <= ISSUE;
                clear_pend    <= bus.s_last;
                bus.s_ready   <= 1'b0;
                bus.out_valid <= 1'b1;
                bus.out_first <= 1'b1;
                bus.out_last  <= (KERNEL_TAPS == 1);
                bus.out_tap   <= '0;
                bus.in_data   <= tap0_data;
                bus.weight    <= w0_new;
              end
            end
          end
        end
        ISSUE: begin
          if (bus.out_tap == LAST_TAP) begin
            state         <= FILL;
            bus.s_ready   <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_tap   <= '0;
            bus.in_data   <= '0;
            bus.weight    <= '0;
            if (clear_pend) begin
              clear_pend <= 1'b0;
              fill_cnt   <= '0;
              for (int unsigned i = 0; i < MAXT; i++) win_q[TW'(i)] <= '0;
            end
          end else begin
            bus.out_tap   <= nxt_tap;
            bus.in_data   <= win_q[nxt_tap];
            bus.weight    <= wt_q[nxt_tap];
            bus.out_first <= 1'b0;
            bus.out_last  <= (nxt_tap == LAST_TAP);
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_tap_feeder.sv
// Directed bench for conv_tap_feeder: a 3-tap instance for the main scenarios and a 1-tap instance.
module tb_conv_tap_feeder;
  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  logic [31:0] w [3];

  conv_tap_feeder_if ia ();
  conv_tap_feeder_if ib ();

  conv_tap_feeder #(.KERNEL_TAPS(3)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  conv_tap_feeder #(.KERNEL_TAPS(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] SA = 32'h11111111, SB = 32'h22222222, SC = 32'h33333333;
  localparam logic [31:0] SD = 32'h44444444, SE = 32'h55555555, SF = 32'h66666666;
  localparam logic [31:0] SG = 32'h77777777, SH = 32'h88888888, SI = 32'h99999999;
  localparam logic [31:0] SJ = 32'hAAAAAAAA;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [4:0] addr, input logic [31:0] data, input logic exp_ack);
    ia.cfg_we    = 1'b1;
    ia.cfg_addr  = addr;
    ia.cfg_wdata = data;
    step();
    ia.cfg_we    = 1'b0;
    chk("cfg_ack", 32'(ia.cfg_ack), 32'(exp_ack));
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    chk("s_ready_before_accept", 32'(ia.s_ready), 32'd1);
    ia.s_valid = 1'b1;
    ia.s_data  = data;
    ia.s_last  = last;
    step();
    ia.s_valid = 1'b0;
    ia.s_last  = 1'b0;
  endtask

  // Called on the cycle right after the completing accept; walks all three taps and the return to FILL.
  task automatic issue_chk(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
    logic [31:0] xs [3];
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", 32'(ia.out_valid), 32'd1);
      chk("in_data",   ia.in_data, xs[i]);
      chk("weight",    ia.weight, w[i]);
      chk("out_first", 32'(ia.out_first), 32'(i == 0));
      chk("out_last",  32'(ia.out_last), 32'(i == 2));
      chk("out_tap",   32'(ia.out_tap), 32'(i));
      chk("s_ready_issue", 32'(ia.s_ready), 32'd0);
      step();
    end
    chk("out_valid_idle", 32'(ia.out_valid), 32'd0);
    chk("s_ready_back",   32'(ia.s_ready), 32'd1);
    chk("in_data_idle",   ia.in_data, 32'd0);
    chk("weight_idle",    ia.weight, 32'd0);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    ia.cfg_we = 1'b0; ia.cfg_addr = '0; ia.cfg_wdata = '0;
    ia.s_valid = 1'b0; ia.s_data = '0; ia.s_last = 1'b0;
    ib.cfg_we = 1'b0; ib.cfg_addr = '0; ib.cfg_wdata = '0;
    ib.s_valid = 1'b0; ib.s_data = '0; ib.s_last = 1'b0;
    w[0] = 32'h3F800000; w[1] = 32'h40000000; w[2] = 32'h40400000;

    reset = 1'b1;
    step();
    step();
    chk("rst_s_ready",   32'(ia.s_ready), 32'd0);
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_bias",      ia.bias, 32'd0);
    chk("rst_in_data",   ia.in_data, 32'd0);
    reset = 1'b0;
    step();
    chk("rel_s_ready", 32'(ia.s_ready), 32'd1);

    // Weights, bias, then first window A,B,C
    cfg_wr(5'd0, w[0], 1'b1);
    cfg_wr(5'd1, w[1], 1'b1);
    cfg_wr(5'd2, w[2], 1'b1);
    cfg_wr(5'h1F, 32'h3F000000, 1'b1);
    chk("bias", ia.bias, 32'h3F000000);
    send(SA, 1'b0);
    chk("no_out_a", 32'(ia.out_valid), 32'd0);
    send(SB, 1'b0);
    chk("no_out_b", 32'(ia.out_valid), 32'd0);
    send(SC, 1'b0);
    issue_chk(SA, SB, SC);
    chk("bias_hold", ia.bias, 32'h3F000000);

    // Sliding window on a saturated count
    send(SD, 1'b0);
    issue_chk(SB, SC, SD);

    // Completing sample with s_last; cfg write held through ISSUE is dropped
    send(SE, 1'b1);
    ia.cfg_we = 1'b1; ia.cfg_addr = 5'd1; ia.cfg_wdata = 32'hDEADBEEF;
    issue_chk(SC, SD, SE);
    ia.cfg_we = 1'b0;
    chk("issue_cfg_ack", 32'(ia.cfg_ack), 32'd0);
    cfg_wr(5'd5, 32'hCAFEF00D, 1'b0);

    // Short frame is discarded, fresh window after it
    send(SA, 1'b0);
    send(SB, 1'b1);
    chk("short_frame_none", 32'(ia.out_valid), 32'd0);
    step();
    chk("short_frame_idle", 32'(ia.out_valid), 32'd0);
    send(SC, 1'b0);
    send(SD, 1'b0);
    chk("refill_none", 32'(ia.out_valid), 32'd0);
    send(SE, 1'b0);
    issue_chk(SC, SD, SE);

    // Weight write and accept in the same cycle
    w[0] = 32'h41000000;
    ia.cfg_we = 1'b1; ia.cfg_addr = 5'd0; ia.cfg_wdata = w[0];
    send(SF, 1'b0);
    ia.cfg_we = 1'b0;
    chk("same_cycle_ack", 32'(ia.cfg_ack), 32'd1);
    issue_chk(SD, SE, SF);

    // Reset on tap 1 aborts the window and clears weights/bias
    send(SG, 1'b0);
    step();
    chk("pre_rst_tap", 32'(ia.out_tap), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_out_valid", 32'(ia.out_valid), 32'd0);
    chk("abort_s_ready",   32'(ia.s_ready), 32'd0);
    chk("abort_in_data",   ia.in_data, 32'd0);
    chk("abort_weight",    ia.weight, 32'd0);
    chk("abort_tap",       32'(ia.out_tap), 32'd0);
    chk("abort_bias",      ia.bias, 32'd0);
    reset = 1'b0;
    step();
    chk("abort_rel_ready", 32'(ia.s_ready), 32'd1);
    w[0] = '0; w[1] = '0; w[2] = '0;
    send(SH, 1'b0);
    send(SI, 1'b0);
    chk("post_rst_refill", 32'(ia.out_valid), 32'd0);
    send(SJ, 1'b0);
    issue_chk(SH, SI, SJ);

    // Single-tap instance
    chk("k1_ready", 32'(ib.s_ready), 32'd1);
    ib.s_valid = 1'b1; ib.s_data = 32'h40A00000;
    step();
    ib.s_valid = 1'b0;
    chk("k1_valid",   32'(ib.out_valid), 32'd1);
    chk("k1_data",    ib.in_data, 32'h40A00000);
    chk("k1_first",   32'(ib.out_first), 32'd1);
    chk("k1_last",    32'(ib.out_last), 32'd1);
    chk("k1_tap",     32'(ib.out_tap), 32'd0);
    chk("k1_weight",  ib.weight, 32'd0);
    chk("k1_busy",    32'(ib.s_ready), 32'd0);
    step();
    chk("k1_idle",    32'(ib.out_valid), 32'd0);
    chk("k1_ready2",  32'(ib.s_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/conv_tap_feeder.md
CONV_TAP_FEEDER -- requirements
Module: conv_tap_feeder

Interface
REQ-001 SHALL have parameter: KERNEL_TAPS, default 9, taps per 1-D window (legal 1..16).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cfg_we  input  1  config write strobe.
REQ-005 SHALL have port: cfg_addr  input  5  0..KERNEL_TAPS-1 = weight slot; 5'h1F = bias.
REQ-006 SHALL have port: cfg_wdata  input  32  FP32 weight/bias bits.
REQ-007 SHALL have port: cfg_ack  output  1  one-cycle pulse for an accepted write.
REQ-008 SHALL have port: s_valid  input  1  input sample valid.
REQ-009 SHALL have port: s_ready  output  1  feeder accepts sample this cycle.
REQ-010 SHALL have port: s_data  input  32  FP32 sample bits.
REQ-011 SHALL have port: s_last  input  1  sample is last of frame.
REQ-012 SHALL have port: in_data  output  32  window sample for current tap, to downstream conv_fp_unit.
REQ-013 SHALL have port: weight  output  32  weight for current tap.
REQ-014 SHALL have port: bias  output  32  bias register, driven continuously.
REQ-015 SHALL have port: out_valid  output  1  in_data/weight valid this cycle.
REQ-016 SHALL have port: out_first  output  1  tap 0 of a window.
REQ-017 SHALL have port: out_last  output  1  tap KERNEL_TAPS-1 of a window.
REQ-018 SHALL have port: out_tap  output  4  current tap index.

Function
REQ-019 SHALL treat the 32-bit values as opaque FP32 bit patterns; no arithmetic on data.
REQ-020 SHALL implement FSM states FILL and ISSUE; s_ready = 1 exactly when state = FILL.
REQ-021 In FILL, handshake s_valid&s_ready SHALL shift sample into window[KERNEL_TAPS-1], window[i] <- window[i+1], and increment fill_cnt (saturating at KERNEL_TAPS).
REQ-022 An accept making fill_cnt = KERNEL_TAPS (or arriving with fill_cnt already = KERNEL_TAPS) SHALL move FILL -> ISSUE at that edge.
REQ-023 ISSUE SHALL emit registered outputs for taps 0..KERNEL_TAPS-1 on consecutive cycles, tap i driving in_data = window[i] (oldest first), weight = weight[i], out_valid = 1.
REQ-024 Latency: accept at cycle t SHALL give out_first at t+1, out_last at t+KERNEL_TAPS, s_ready = 1 again at t+KERNEL_TAPS+1.
REQ-025 No downstream back-pressure: once started, a window SHALL issue without stalls.
REQ-026 out_first/out_last both SHALL assert on the single tap when KERNEL_TAPS = 1.
REQ-027 Outside ISSUE, out_valid/out_first/out_last SHALL be 0 and in_data/weight/out_tap SHALL be 0.
REQ-028 Sample with s_last = 1 that completes a window SHALL issue normally, then fill_cnt and window SHALL clear to 0 when returning to FILL.
REQ-029 Sample with s_last = 1 that does not complete a window SHALL clear fill_cnt and window at that edge with no output issued.
REQ-030 cfg write in FILL with legal address SHALL update the register at the edge and pulse cfg_ack next cycle.
REQ-031 cfg write in ISSUE or to an illegal address SHALL be dropped with no cfg_ack.
REQ-032 A cfg write and sample accept in the same FILL cycle SHALL both take effect; the resulting window uses the new weight.

Reset
REQ-033 Reset SHALL set state FILL, fill_cnt 0, window, weights and bias to 0, and all outputs to 0 except s_ready.
REQ-034 s_ready SHALL be 0 while reset is high and 1 in the first cycle after release.
REQ-035 Reset during ISSUE SHALL abort the window; out_valid SHALL be 0 from the cycle after the reset edge.

Verification
REQ-036 KERNEL_TAPS=3, weights 0x3F800000/0x40000000/0x40400000, bias 0x3F000000, samples A,B,C -> taps 0,1,2 emit (A,w0),(B,w1),(C,w2), bias 0x3F000000, first/last on taps 0/2.
REQ-037 Continue with sample D (no s_last) -> window B,C,D issued, 3 cycles after accept; s_ready low exactly 3 cycles.
REQ-038 Send A,B with s_last on B -> no out_valid; next C,D,E -> window C,D,E.
REQ-039 cfg write during ISSUE -> no cfg_ack, weight unchanged; write to addr 5 (K=3) -> no cfg_ack.
REQ-040 Assert reset on tap 1 of a window -> out_valid 0 next cycle, all registers 0, s_ready 1 after release.
REQ-041 KERNEL_TAPS=1, single sample 0x40A00000 -> one cycle out_valid with out_first=out_last=1, out_tap 0.
